// File: rtl/transceiver_seq_pkg.sv
// Shared definitions for the transceiver lane bring-up sequencer:
// FSM state encoding, parameter defaults and a sizing helper.
package transceiver_seq_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_PLL   = 3'd0,
        ST_RESTART    = 3'd1,
        ST_WAIT_READY = 3'd2,
        ST_LINK_UP    = 3'd3,
        ST_FAIL       = 3'd4
    } seq_state_e;

    localparam int unsigned DEFAULT_NUMBER_OF_LANES    = 6;
    localparam int unsigned DEFAULT_LOCK_STABLE_CYCLES = 1024;
    localparam int unsigned DEFAULT_RESTART_CYCLES     = 64;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES     = 65536;
    localparam int unsigned DEFAULT_MAX_RETRIES        = 7;

    localparam logic [1:0] PLL_ALL_LOCKED = 2'b11;

    // Largest of three cycle counts; sizes the single shared timer.
    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter with a terminal flag. Shared by the PLL stability
// wait, the restart pulse and the ready timeout; only one is ever active.
module seq_timer #(
    parameter int unsigned       g_Width      = 16,
    parameter logic [g_Width-1:0] g_ResetValue = '0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               load_i,
    input  logic [g_Width-1:0] load_value_i,
    input  logic               dec_i,
    output logic               terminal_o
);

    localparam logic [g_Width-1:0] One = g_Width'(1);

    logic [g_Width-1:0] count_q;
    logic [g_Width-1:0] count_d;

    // Load wins over decrement; the count holds at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_value_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - One;
        end
    end

    // Count register, synchronous reset to the caller's start value.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= g_ResetValue;
        end else begin
            count_q <= count_d;
        end
    end

    assign terminal_o = (count_q == '0);

endmodule

// File: rtl/lane_bringup_sequencer.sv
// Lane bring-up sequencer: waits for stable TX PLL lock, pulses the lane
// restart, waits for all lanes ready with a bounded retry budget, then
// supervises the link and re-runs bring-up on a drop.
//
// state         | meaning
// --------------+-----------------------------------------------------
// ST_WAIT_PLL   | counting consecutive cycles with both PLLs locked
// ST_RESTART    | Lanes_Restart asserted for the restart pulse width
// ST_WAIT_READY | waiting for every lane ready, bounded by the timeout
// ST_LINK_UP    | all lanes up; any not-ready or error drops the link
// ST_FAIL       | retries exhausted; only a restart request leaves
module lane_bringup_sequencer
    import transceiver_seq_pkg::*;
#(
    parameter int unsigned g_NumberOfLanes    = DEFAULT_NUMBER_OF_LANES,
    parameter int unsigned g_LockStableCycles = DEFAULT_LOCK_STABLE_CYCLES,
    parameter int unsigned g_RestartCycles    = DEFAULT_RESTART_CYCLES,
    parameter int unsigned g_TimeoutCycles    = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned g_MaxRetries       = DEFAULT_MAX_RETRIES
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic [1:0]                 pll_lock_i,
    input  logic                       restart_request_i,
    input  logic [g_NumberOfLanes-1:0] lane_ready_vector_i,
    input  logic [g_NumberOfLanes-1:0] lane_error_vector_i,
    output logic                       lanes_restart_o,
    output logic                       link_up_o,
    output logic                       fail_o,
    output logic [3:0]                 retry_count_o,
    output logic [7:0]                 drop_count_o,
    output logic [2:0]                 state_out_o
);

    localparam int unsigned TimerSpan  = max3(g_LockStableCycles, g_RestartCycles, g_TimeoutCycles);
    localparam int unsigned TimerWidth = (TimerSpan > 1) ? $clog2(TimerSpan) : 1;

    // The timer terminates on zero, so each phase loads its length minus one.
    localparam logic [TimerWidth-1:0] LockLoad    = TimerWidth'(g_LockStableCycles - 1);
    localparam logic [TimerWidth-1:0] RestartLoad = TimerWidth'(g_RestartCycles - 1);
    localparam logic [TimerWidth-1:0] TimeoutLoad = TimerWidth'(g_TimeoutCycles - 1);
    localparam logic [3:0]            MaxRetries  = 4'(g_MaxRetries);

    seq_state_e state_q, state_d;
    logic [3:0] retry_q, retry_d;
    logic [7:0] drop_q, drop_d;
    logic       lanes_restart_q;
    logic       link_up_q;
    logic       fail_q;

    logic                  tmr_load;
    logic [TimerWidth-1:0] tmr_load_value;
    logic                  tmr_dec;
    logic                  tmr_terminal;

    logic pll_locked;
    logic all_ready;
    logic any_error;

    assign pll_locked = (pll_lock_i == PLL_ALL_LOCKED);
    assign all_ready  = &lane_ready_vector_i;
    assign any_error  = |lane_error_vector_i;

    seq_timer #(
        .g_Width      (TimerWidth),
        .g_ResetValue (LockLoad)
    ) u_seq_timer (
        .clk_i        (clock_i),
        .reset_i      (reset_i),
        .load_i       (tmr_load),
        .load_value_i (tmr_load_value),
        .dec_i        (tmr_dec),
        .terminal_o   (tmr_terminal)
    );

    // Next state, counters and timer control; restart request beats PLL loss,
    // which beats lane status and timeout.
    always_comb begin
        state_d        = state_q;
        retry_d        = retry_q;
        drop_d         = drop_q;
        tmr_load       = 1'b0;
        tmr_load_value = LockLoad;
        tmr_dec        = 1'b0;

        if (restart_request_i) begin
            state_d  = ST_WAIT_PLL;
            retry_d  = '0;
            tmr_load = 1'b1;
        end else begin
            case (state_q)
                ST_WAIT_PLL: begin
                    if (!pll_locked) begin
                        tmr_load = 1'b1;
                    end else if (tmr_terminal) begin
                        state_d        = ST_RESTART;
                        tmr_load       = 1'b1;
                        tmr_load_value = RestartLoad;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                ST_RESTART: begin
                    if (!pll_locked) begin
                        state_d  = ST_WAIT_PLL;
                        tmr_load = 1'b1;
                    end else if (tmr_terminal) begin
                        state_d        = ST_WAIT_READY;
                        tmr_load       = 1'b1;
                        tmr_load_value = TimeoutLoad;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                ST_WAIT_READY: begin
                    if (!pll_locked) begin
                        state_d  = ST_WAIT_PLL;
                        tmr_load = 1'b1;
                    end else if (all_ready) begin
                        state_d = ST_LINK_UP;
                        retry_d = '0;
                    end else if (tmr_terminal) begin
                        if (retry_q == MaxRetries) begin
                            state_d = ST_FAIL;
                        end else begin
                            state_d        = ST_RESTART;
                            retry_d        = retry_q + 4'd1;
                            tmr_load       = 1'b1;
                            tmr_load_value = RestartLoad;
                        end
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                ST_LINK_UP: begin
                    if (!pll_locked) begin
                        state_d  = ST_WAIT_PLL;
                        tmr_load = 1'b1;
                    end else if (!all_ready || any_error) begin
                        state_d        = ST_RESTART;
                        tmr_load       = 1'b1;
                        tmr_load_value = RestartLoad;
                        if (drop_q != 8'hFF) begin
                            drop_d = drop_q + 8'd1;
                        end
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d  = ST_WAIT_PLL;
                    tmr_load = 1'b1;
                end
            endcase
        end
    end

    // State, counters and status outputs, all registered from the next state.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q         <= ST_WAIT_PLL;
            retry_q         <= '0;
            drop_q          <= '0;
            lanes_restart_q <= 1'b0;
            link_up_q       <= 1'b0;
            fail_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            retry_q         <= retry_d;
            drop_q          <= drop_d;
            lanes_restart_q <= (state_d == ST_RESTART);
            link_up_q       <= (state_d == ST_LINK_UP);
            fail_q          <= (state_d == ST_FAIL);
        end
    end

    assign lanes_restart_o = lanes_restart_q;
    assign link_up_o       = link_up_q;
    assign fail_o          = fail_q;
    assign retry_count_o   = retry_q;
    assign drop_count_o    = drop_q;
    assign state_out_o     = state_q;

endmodule

// File: tb/tb_lane_bringup_sequencer.sv
// Scoreboard bench for lane_bringup_sequencer: stimulus drives inputs on the
// falling edge and pushes the reference model's expected outputs; a monitor
// pops and compares after each rising edge.
module tb_lane_bringup_sequencer;

    localparam int NL   = 6;
    localparam int LOCK = 4;
    localparam int RSTC = 8;
    localparam int TO   = 100;
    localparam int MAXR = 2;

    localparam int M_WAIT_PLL   = 0;
    localparam int M_RESTART    = 1;
    localparam int M_WAIT_READY = 2;
    localparam int M_LINK_UP    = 3;
    localparam int M_FAIL       = 4;

    typedef struct packed {
        logic       lr;
        logic       lu;
        logic       fl;
        logic [3:0] rc;
        logic [7:0] dc;
        logic [2:0] so;
    } out_t;

    typedef struct {
        string name;
        int    idx;
        out_t  v;
        int    pulse;
    } dir_t;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic [1:0]    pll_lock_i = 2'b00;
    logic          restart_request_i = 1'b0;
    logic [NL-1:0] lane_ready_vector_i = '0;
    logic [NL-1:0] lane_error_vector_i = '0;
    logic          lanes_restart_o;
    logic          link_up_o;
    logic          fail_o;
    logic [3:0]    retry_count_o;
    logic [7:0]    drop_count_o;
    logic [2:0]    state_out_o;

    out_t exp_q[$];
    dir_t dir_q[$];
    bit   stim_done = 1'b0;
    int   step_idx = 0;

    int unsigned tests_run = 0;
    int unsigned tests_failed = 0;

    // reference model: up-counting elapsed times, plain integers
    int m_st = M_WAIT_PLL;
    int m_stable = 0;
    int m_elapsed = 0;
    int m_retry = 0;
    int m_drop = 0;

    always #5 clk = ~clk;

    lane_bringup_sequencer #(
        .g_NumberOfLanes    (NL),
        .g_LockStableCycles (LOCK),
        .g_RestartCycles    (RSTC),
        .g_TimeoutCycles    (TO),
        .g_MaxRetries       (MAXR)
    ) dut (
        .clock_i             (clk),
        .reset_i             (reset_i),
        .pll_lock_i          (pll_lock_i),
        .restart_request_i   (restart_request_i),
        .lane_ready_vector_i (lane_ready_vector_i),
        .lane_error_vector_i (lane_error_vector_i),
        .lanes_restart_o     (lanes_restart_o),
        .link_up_o           (link_up_o),
        .fail_o              (fail_o),
        .retry_count_o       (retry_count_o),
        .drop_count_o        (drop_count_o),
        .state_out_o         (state_out_o)
    );

    function automatic string fmt(input out_t v);
        return $sformatf("st=%0d lr=%b lu=%b fail=%b retry=%0d drop=%0d",
                         v.so, v.lr, v.lu, v.fl, v.rc, v.dc);
    endfunction

    function automatic out_t model_out();
        out_t v;
        v.lr = (m_st == M_RESTART);
        v.lu = (m_st == M_LINK_UP);
        v.fl = (m_st == M_FAIL);
        v.rc = 4'(m_retry);
        v.dc = 8'(m_drop);
        v.so = 3'(m_st);
        return v;
    endfunction

    task automatic model_step(input bit rst, input bit req, input logic [1:0] lock,
                              input logic [NL-1:0] rdy, input logic [NL-1:0] err);
        bit locked;
        bit all_rdy;
        locked  = (lock == 2'b11);
        all_rdy = (rdy == {NL{1'b1}});
        if (rst) begin
            m_st = M_WAIT_PLL; m_stable = 0; m_elapsed = 0; m_retry = 0; m_drop = 0;
        end else if (req) begin
            m_st = M_WAIT_PLL; m_stable = 0; m_retry = 0;
        end else if (m_st == M_FAIL) begin
            m_st = M_FAIL;
        end else if (!locked) begin
            m_st = M_WAIT_PLL; m_stable = 0;
        end else if (m_st == M_WAIT_PLL) begin
            m_stable++;
            if (m_stable == LOCK) begin
                m_st = M_RESTART; m_elapsed = 0;
            end
        end else if (m_st == M_RESTART) begin
            m_elapsed++;
            if (m_elapsed == RSTC) begin
                m_st = M_WAIT_READY; m_elapsed = 0;
            end
        end else if (m_st == M_WAIT_READY) begin
            m_elapsed++;
            if (all_rdy) begin
                m_st = M_LINK_UP; m_retry = 0;
            end else if (m_elapsed == TO) begin
                if (m_retry == MAXR) begin
                    m_st = M_FAIL;
                end else begin
                    m_retry++; m_st = M_RESTART; m_elapsed = 0;
                end
            end
        end else begin
            if (!all_rdy || err != '0) begin
                m_st = M_RESTART; m_elapsed = 0;
                m_drop = (m_drop < 255) ? m_drop + 1 : 255;
            end
        end
    endtask

    task automatic step(input bit rst, input bit req, input logic [1:0] lock,
                        input logic [NL-1:0] rdy, input logic [NL-1:0] err);
        @(negedge clk);
        reset_i             = rst;
        restart_request_i   = req;
        pll_lock_i          = lock;
        lane_ready_vector_i = rdy;
        lane_error_vector_i = err;
        model_step(rst, req, lock, rdy, err);
        exp_q.push_back(model_out());
        step_idx++;
    endtask

    task automatic idle(input int n, input logic [NL-1:0] rdy);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 2'b11, rdy, '0);
    endtask

    // Directed expectation for the most recent step, written from scenario constants.
    task automatic expect_dir(input string name, input logic lr, input logic lu, input logic fl,
                              input int rc, input int dc, input int so, input int pulse);
        dir_t d;
        d.name  = name;
        d.idx   = step_idx - 1;
        d.v.lr  = lr;
        d.v.lu  = lu;
        d.v.fl  = fl;
        d.v.rc  = 4'(rc);
        d.v.dc  = 8'(dc);
        d.v.so  = 3'(so);
        d.pulse = pulse;
        dir_q.push_back(d);
    endtask

    task automatic reach_state(input int target, input logic [NL-1:0] rdy);
        for (int k = 0; k < 300 && m_st != target; k++) step(1'b0, 1'b0, 2'b11, rdy, '0);
    endtask

    // Monitor: compare every presented output against the scoreboard.
    int pop_idx = 0;
    int pulse_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            out_t e;
            out_t a;
            e = exp_q.pop_front();
            a = {lanes_restart_o, link_up_o, fail_o, retry_count_o, drop_count_o, state_out_o};
            if (lanes_restart_o === 1'b1) pulse_cnt++;
            tests_run++;
            if (a !== e) begin
                tests_failed++;
                $display("FAIL cycle_model step=%0d got %s required %s", pop_idx, fmt(a), fmt(e));
            end
            while (dir_q.size() > 0 && dir_q[0].idx == pop_idx) begin
                dir_t d;
                d = dir_q.pop_front();
                tests_run++;
                if (a !== d.v) begin
                    tests_failed++;
                    $display("FAIL %s got %s required %s", d.name, fmt(a), fmt(d.v));
                end
                if (d.pulse >= 0) begin
                    tests_run++;
                    if (pulse_cnt != d.pulse) begin
                        tests_failed++;
                        $display("FAIL %s_pulse_cycles got %0d required %0d", d.name, pulse_cnt, d.pulse);
                    end
                end
                pulse_cnt = 0;
            end
            pop_idx++;
        end
        if (stim_done && exp_q.size() == 0) begin
            if (dir_q.size() != 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL directed_leftover got %0d required 0", dir_q.size());
            end
            $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
            $finish;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]    lock;
        logic [NL-1:0] rdy;
        logic [NL-1:0] err;
        bit            rst;
        bit            req;
        int            mode;

        // reset overrides a concurrent restart request
        step(1'b1, 1'b1, 2'b11, '0, '0);
        step(1'b1, 1'b0, 2'b11, '0, '0);
        step(1'b1, 1'b1, 2'b00, '0, '1);
        expect_dir("reset_state", 0, 0, 0, 0, 0, 0, -1);

        // nominal bring-up: ready 20 cycles after the restart pulse
        idle(LOCK + RSTC + 20, '0);
        step(1'b0, 1'b0, 2'b11, '1, '0);
        expect_dir("nominal_linkup", 0, 1, 0, 0, 0, 3, 8);

        // lock glitch restarts the stability count
        step(1'b1, 1'b0, 2'b11, '0, '0);
        expect_dir("glitch_reset", 0, 0, 0, 0, 0, 0, -1);
        idle(3, '0);
        step(1'b0, 1'b0, 2'b01, '0, '0);
        idle(3, '0);
        expect_dir("glitch_hold", 0, 0, 0, 0, 0, 0, 0);
        idle(1, '0);
        expect_dir("glitch_restart", 1, 0, 0, 0, 0, 1, 1);

        // timeout exhaustion: three pulses then FAIL, cleared by restart request
        step(1'b1, 1'b0, 2'b11, '0, '0);
        expect_dir("exhaust_reset", 0, 0, 0, 0, 0, 0, -1);
        idle(LOCK + (MAXR + 1) * (RSTC + TO), '0);
        expect_dir("exhaust_fail", 0, 0, 1, 2, 0, 4, 3 * RSTC);
        idle(5, '0);
        step(1'b0, 1'b1, 2'b11, '0, '0);
        expect_dir("exhaust_clear", 0, 0, 0, 0, 0, 0, -1);

        // link drops: first by lane 3 error, then until the counter saturates
        reach_state(M_LINK_UP, '1);
        expect_dir("drop_linkup", 0, 1, 0, 0, 0, 3, -1);
        err = '0; err[3] = 1'b1;
        step(1'b0, 1'b0, 2'b11, '1, err);
        expect_dir("drop_first", 1, 0, 0, 0, 1, 1, -1);
        for (int d = 0; d < 299; d++) begin
            reach_state(M_LINK_UP, '1);
            rdy = '1;
            err = '0;
            if (d % 2 == 0) err[$urandom_range(NL - 1, 0)] = 1'b1;
            else            rdy[$urandom_range(NL - 1, 0)] = 1'b0;
            step(1'b0, 1'b0, 2'b11, rdy, err);
        end
        expect_dir("drop_saturate", 1, 0, 0, 0, 255, 1, -1);

        // restart request with PLL loss in the same cycle
        reach_state(M_LINK_UP, '1);
        step(1'b0, 1'b1, 2'b01, '1, '0);
        expect_dir("collide_req_pll", 0, 0, 0, 0, 255, 0, -1);

        // ready in the very cycle the timeout expires
        reach_state(M_WAIT_READY, '0);
        idle(TO - 1, '0);
        step(1'b0, 1'b0, 2'b11, '1, '0);
        expect_dir("collide_ready_timeout", 0, 1, 0, 0, 255, 3, -1);

        // reset during the fourth cycle of a restart pulse
        reach_state(M_RESTART, '0);
        idle(3, '0);
        step(1'b1, 1'b0, 2'b11, '0, '0);
        expect_dir("reset_mid_restart", 0, 0, 0, 0, 0, 0, 4);

        // randomized phase against the reference model
        mode = 0;
        for (int i = 0; i < 6000; i++) begin
            if (i % 256 == 0) mode = int'($urandom_range(2, 0));
            rst  = ($urandom_range(499, 0) == 0);
            req  = ($urandom_range(299, 0) == 0);
            lock = ($urandom_range(299, 0) == 0) ? 2'($urandom_range(2, 0)) : 2'b11;
            err  = '0;
            if (mode == 0) begin
                rdy = NL'($urandom);
                rdy[$urandom_range(NL - 1, 0)] = 1'b0;
            end else if (mode == 1) begin
                rdy = ($urandom_range(3, 0) == 0) ? {NL{1'b1}} : NL'($urandom);
                if ($urandom_range(49, 0) == 0) err[$urandom_range(NL - 1, 0)] = 1'b1;
            end else begin
                rdy = '1;
                if ($urandom_range(49, 0) == 0) rdy[$urandom_range(NL - 1, 0)] = 1'b0;
                if ($urandom_range(49, 0) == 0) err[$urandom_range(NL - 1, 0)] = 1'b1;
            end
            step(rst, req, lock, rdy, err);
        end

        @(negedge clk);
        stim_done = 1'b1;
    end

endmodule
